// File: rtl/isa_addr_fifo_gated.sv
// Wide-in / narrow-out address FIFO, words leave MSB slice first.
// Define ISA_FIFO_BUSY_GATE_EN to hold off pops after busy-page words.
module isa_addr_fifo_gated #(
  parameter int          OUT_W      = 32,
  parameter int          RATIO      = 4,
  parameter int          DEPTH      = 16,
  parameter int          HOLD       = 2,
  parameter logic [19:0] BUSY_PAGE0 = 20'h02001,
  parameter logic [19:0] BUSY_PAGE1 = 20'h02002
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [OUT_W*RATIO-1:0]              din,
  input  logic                                wr_en,
  input  logic                                tx_ready,
  output logic [OUT_W-1:0]                    dout,
  output logic                                valid,
  output logic                                full,
  output logic                                empty,
  output logic [$clog2(DEPTH*RATIO):0]        level,
  output logic                                overflow
);

  localparam int IN_W  = OUT_W * RATIO;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int SL_W  = $clog2(RATIO);
  localparam int ENT_W = PTR_W + 1;
  localparam int LVL_W = $clog2(DEPTH * RATIO) + 1;

  logic [IN_W-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [SL_W-1:0]  slice_q, slice_d;
  logic [ENT_W-1:0] ent_q, ent_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic [OUT_W-1:0] dout_q, dout_d;

  logic             stall;
  logic             rd_go;
  logic             last_pop;
  logic             wr_acc;
  logic [IN_W-1:0]  rd_word;

`ifdef ISA_FIFO_BUSY_GATE_EN
  logic [3:0] hold_q, hold_d;
  logic       busy_hit;

  always_comb begin
    busy_hit = valid_q &
      ((dout_q[OUT_W-1 -: 20] == BUSY_PAGE0) |
       (dout_q[OUT_W-1 -: 20] == BUSY_PAGE1));
    hold_d = hold_q;
    if (busy_hit)
      hold_d = HOLD[3:0];
    else if (hold_q != 4'd0)
      hold_d = hold_q - 4'd1;
    stall = busy_hit | (hold_q != 4'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) hold_q <= '0;
    else     hold_q <= hold_d;
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{BUSY_PAGE0, BUSY_PAGE1, HOLD[3:0]};
  assign stall      = 1'b0;
`endif

  always_comb begin
    rd_go    = ~empty_q & tx_ready & ~stall;
    last_pop = rd_go & (slice_q == SL_W'(RATIO - 1));
    // A full FIFO still takes a write when the head entry frees this cycle
    wr_acc   = wr_en & (~full_q | last_pop);
    rd_word  = mem_q[rd_ptr_q];

    wr_ptr_d = wr_acc   ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = last_pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    slice_d = slice_q;
    if (last_pop)
      slice_d = '0;
    else if (rd_go)
      slice_d = slice_q + SL_W'(1);

    ent_d = ent_q;
    if (wr_acc)   ent_d = ent_d + ENT_W'(1);
    if (last_pop) ent_d = ent_d - ENT_W'(1);

    level_d = level_q;
    if (wr_acc) level_d = level_d + LVL_W'(RATIO);
    if (rd_go)  level_d = level_d - LVL_W'(1);

    full_d  = (ent_d == ENT_W'(DEPTH));
    empty_d = (level_d == '0);
    valid_d = rd_go;
    dout_d  = rd_go ?
      rd_word[IN_W-1 - int'(slice_q)*OUT_W -: OUT_W] : dout_q;
    ovf_d   = ovf_q | (wr_en & ~wr_acc);
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_acc)
      mem_q[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      slice_q  <= '0;
      ent_q    <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      slice_q  <= slice_d;
      ent_q    <= ent_d;
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      dout_q   <= dout_d;
    end
  end

  assign dout     = dout_q;
  assign valid    = valid_q;
  assign full     = full_q;
  assign empty    = empty_q;
  assign level    = level_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_isa_addr_fifo_gated.sv
// Bench for isa_addr_fifo_gated: directed scenarios plus random traffic
// checked each cycle against a word-queue reference model.
module tb_isa_addr_fifo_gated;

  localparam int OUT_W = 32;
  localparam int RATIO = 4;
  localparam int DEPTH = 16;
  localparam int HOLD  = 2;
  localparam logic [19:0] P0 = 20'h02001;
  localparam logic [19:0] P1 = 20'h02002;
`ifdef ISA_FIFO_BUSY_GATE_EN
  localparam bit GATED = 1'b1;
`else
  localparam bit GATED = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [OUT_W*RATIO-1:0] din = '0;
  logic                   wr_en = 1'b0;
  logic                   tx_ready = 1'b0;
  logic [OUT_W-1:0]       dout;
  logic                   valid;
  logic                   full;
  logic                   empty;
  logic [$clog2(DEPTH*RATIO):0] level;
  logic                   overflow;

  isa_addr_fifo_gated #(
    .OUT_W(OUT_W), .RATIO(RATIO), .DEPTH(DEPTH), .HOLD(HOLD),
    .BUSY_PAGE0(P0), .BUSY_PAGE1(P1)
  ) dut (
    .clk(clk), .rst(rst), .din(din), .wr_en(wr_en),
    .tx_ready(tx_ready), .dout(dout), .valid(valid), .full(full),
    .empty(empty), .level(level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [OUT_W-1:0] mq[$];
  logic             m_valid = 1'b0;
  logic [OUT_W-1:0] m_dout = '0;
  logic             m_ovf = 1'b0;
  int               mcyc = 0;
  int               last_busy = -1000;

  bit               log_en = 1'b0;
  logic [OUT_W-1:0] got[$];
  int               gotc[$];

  function automatic bit is_busy(logic [OUT_W-1:0] w);
    return GATED && (w[OUT_W-1 -: 20] == P0 || w[OUT_W-1 -: 20] == P1);
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(bit r, bit w, logic [OUT_W*RATIO-1:0] d, bit rdy);
    int lvl;
    int ents;
    bit mfull, stall, go, lastp, acc;
    if (r) begin
      mq.delete();
      m_valid = 1'b0;
      m_dout = '0;
      m_ovf = 1'b0;
      last_busy = -1000;
      mcyc++;
      return;
    end
    lvl = mq.size();
    ents = (lvl + RATIO - 1) / RATIO;
    mfull = (ents == DEPTH);
    if (m_valid && is_busy(m_dout)) last_busy = mcyc;
    stall = (mcyc - last_busy) <= HOLD;
    go = (lvl > 0) && rdy && !stall;
    lastp = go && (lvl % RATIO == 1);
    acc = w && (!mfull || lastp);
    m_valid = go;
    if (go) m_dout = mq.pop_front();
    if (acc)
      for (int i = RATIO - 1; i >= 0; i--)
        mq.push_back(d[i*OUT_W +: OUT_W]);
    if (w && !acc) m_ovf = 1'b1;
    mcyc++;
  endtask

  task automatic check_outs();
    int n;
    n = mq.size();
    chk("valid", 64'(valid), 64'(m_valid));
    chk("dout", 64'(dout), 64'(m_dout));
    chk("level", 64'(level), 64'(n));
    chk("full", 64'(full), 64'((n + RATIO - 1) / RATIO == DEPTH));
    chk("empty", 64'(empty), 64'(n == 0));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    if (log_en && valid === 1'b1) begin
      got.push_back(dout);
      gotc.push_back(mcyc);
    end
  endtask

  task automatic step(bit r, bit w, logic [OUT_W*RATIO-1:0] d, bit rdy);
    rst = r;
    wr_en = w;
    din = d;
    tx_ready = rdy;
    @(posedge clk);
    model_edge(r, w, d, rdy);
    @(negedge clk);
    check_outs();
  endtask

  function automatic logic [OUT_W*RATIO-1:0] seq_entry(int base);
    logic [OUT_W*RATIO-1:0] e;
    for (int k = 0; k < RATIO; k++)
      e[(RATIO-1-k)*OUT_W +: OUT_W] = 32'h0000_1000 + 32'(base + k);
    return e;
  endfunction

  function automatic logic [OUT_W-1:0] rand_word();
    logic [OUT_W-1:0] w;
    w = $urandom;
    if ($urandom_range(0, 3) == 0)
      w[OUT_W-1 -: 20] = ($urandom_range(0, 1) == 0) ? P0 : P1;
    return w;
  endfunction

  logic [OUT_W-1:0] e35[4];
  logic [OUT_W*RATIO-1:0] rd;
  int want_gap;

  initial begin
    e35[0] = 32'h02001000;
    e35[1] = 32'h02002000;
    e35[2] = 32'h02003000;
    e35[3] = 32'h02001000;

    // reset state
    step(1, 1, '1, 1);
    step(1, 0, '0, 0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_dout", 64'(dout), 64'd0);

    // one busy-page entry, continuous ready
    got.delete();
    gotc.delete();
    log_en = 1'b1;
    step(0, 1, 128'h02001000_02002000_02003000_02001000, 1);
    chk("seq_level4", 64'(level), 64'd4);
    repeat (20) step(0, 0, '0, 1);
    log_en = 1'b0;
    chk("seq_count", 64'(got.size()), 64'd4);
    for (int i = 0; i < got.size() && i < 4; i++)
      chk("seq_word", 64'(got[i]), 64'(e35[i]));
    for (int i = 0; i + 1 < gotc.size() && i < 3; i++) begin
      want_gap = is_busy(e35[i]) ? HOLD + 2 : 1;
      chk("seq_gap", 64'(gotc[i+1] - gotc[i]), 64'(want_gap));
    end
    chk("seq_level0", 64'(level), 64'd0);

    // fill past capacity, no reads
    step(1, 0, '0, 0);
    for (int i = 0; i < DEPTH + 1; i++) begin
      step(0, 1, seq_entry(4 * i), 0);
      if (i == DEPTH - 1) begin
        chk("fill_full", 64'(full), 64'd1);
        chk("fill_level", 64'(level), 64'(DEPTH * RATIO));
        chk("fill_noovf", 64'(overflow), 64'd0);
      end
    end
    chk("ovf_set", 64'(overflow), 64'd1);
    chk("ovf_level", 64'(level), 64'(DEPTH * RATIO));
    repeat (3) step(0, 0, '0, 1);
    chk("ovf_sticky", 64'(overflow), 64'd1);
    step(1, 0, '0, 0);
    chk("ovf_cleared", 64'(overflow), 64'd0);

    // simultaneous free and fill while full
    for (int i = 0; i < DEPTH; i++) step(0, 1, seq_entry(4 * i), 0);
    repeat (3) step(0, 0, '0, 1);
    chk("sim_level61", 64'(level), 64'd61);
    chk("sim_full61", 64'(full), 64'd1);
    step(0, 1, seq_entry(200), 1);
    chk("sim_level64", 64'(level), 64'd64);
    chk("sim_full64", 64'(full), 64'd1);
    chk("sim_noovf", 64'(overflow), 64'd0);

    // ready toggling every 5 cycles
    step(1, 0, '0, 0);
    got.delete();
    gotc.delete();
    log_en = 1'b1;
    for (int c = 0; c < 200; c++)
      step(0, c < 8, seq_entry(4 * c), ((c / 5) % 2) == 0);
    log_en = 1'b0;
    chk("tog_count", 64'(got.size()), 64'd32);
    for (int i = 0; i < got.size() && i < 32; i++)
      chk("tog_word", 64'(got[i]), 64'(32'h0000_1000 + 32'(i)));

    // reset mid-operation
    step(1, 0, '0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, seq_entry(4 * i), 0);
    repeat (2) step(0, 0, '0, 1);
    chk("mid_level10", 64'(level), 64'd10);
    step(1, 1, seq_entry(99), 1);
    chk("mid_level0", 64'(level), 64'd0);
    chk("mid_empty", 64'(empty), 64'd1);
    chk("mid_valid", 64'(valid), 64'd0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, '0, 1);
      chk("mid_novalid", 64'(valid), 64'd0);
    end

    // random traffic in phases biased toward filling and draining
    for (int ph = 0; ph < 4; ph++) begin
      for (int c = 0; c < 150; c++) begin
        for (int k = 0; k < RATIO; k++) rd[k*OUT_W +: OUT_W] = rand_word();
        step($urandom_range(0, 99) == 0,
             (ph % 2 == 0) ? ($urandom_range(0, 3) != 0)
                           : ($urandom_range(0, 5) == 0),
             rd,
             (ph % 2 == 0) ? ($urandom_range(0, 3) == 0)
                           : ($urandom_range(0, 3) != 0));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
